// File: rtl/axil_demux_if.sv
`default_nettype none
// ============================================================================
// Module      : axil_demux_if
// Description : Bundles the single upstream AXI4-Lite master port and the
//               NUM_SLAVES packed downstream slave ports of axil_demux.
//               Modport "slave" is the demux view: it is the slave of the
//               upstream bridge and drives the downstream peripherals.
//               Modport "master" is the opposite view, used by the logic
//               that drives the bridge side and models the peripherals.
// Ports       : m_*  upstream AW/W/B/AR/R channels (32-bit addr/data)
//               s_*  per-slave channels, packed NUM_SLAVES wide
// Revision    : 1.0 - initial release
// ============================================================================
interface axil_demux_if #(
    parameter int NUM_SLAVES = 4
) ();
    // Upstream master side
    logic [31:0]              m_awaddr;
    logic                     m_awvalid;
    logic                     m_awready;
    logic [31:0]              m_wdata;
    logic [3:0]               m_wstrb;
    logic                     m_wvalid;
    logic                     m_wready;
    logic                     m_bvalid;
    logic                     m_bready;
    logic [1:0]               m_bresp;
    logic [31:0]              m_araddr;
    logic                     m_arvalid;
    logic                     m_arready;
    logic [31:0]              m_rdata;
    logic [1:0]               m_rresp;
    logic                     m_rvalid;
    logic                     m_rready;
    // Downstream slave side
    logic [NUM_SLAVES*32-1:0] s_awaddr;
    logic [NUM_SLAVES-1:0]    s_awvalid;
    logic [NUM_SLAVES-1:0]    s_awready;
    logic [NUM_SLAVES*32-1:0] s_wdata;
    logic [NUM_SLAVES*4-1:0]  s_wstrb;
    logic [NUM_SLAVES-1:0]    s_wvalid;
    logic [NUM_SLAVES-1:0]    s_wready;
    logic [NUM_SLAVES-1:0]    s_bvalid;
    logic [NUM_SLAVES-1:0]    s_bready;
    logic [NUM_SLAVES*2-1:0]  s_bresp;
    logic [NUM_SLAVES*32-1:0] s_araddr;
    logic [NUM_SLAVES-1:0]    s_arvalid;
    logic [NUM_SLAVES-1:0]    s_arready;
    logic [NUM_SLAVES*32-1:0] s_rdata;
    logic [NUM_SLAVES*2-1:0]  s_rresp;
    logic [NUM_SLAVES-1:0]    s_rvalid;
    logic [NUM_SLAVES-1:0]    s_rready;

    modport slave (
        input  m_awaddr, m_awvalid, m_wdata, m_wstrb, m_wvalid, m_bready,
               m_araddr, m_arvalid, m_rready,
        output m_awready, m_wready, m_bvalid, m_bresp,
               m_arready, m_rdata, m_rresp, m_rvalid,
        output s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
               s_araddr, s_arvalid, s_rready,
        input  s_awready, s_wready, s_bvalid, s_bresp,
               s_arready, s_rdata, s_rresp, s_rvalid
    );

    modport master (
        output m_awaddr, m_awvalid, m_wdata, m_wstrb, m_wvalid, m_bready,
               m_araddr, m_arvalid, m_rready,
        input  m_awready, m_wready, m_bvalid, m_bresp,
               m_arready, m_rdata, m_rresp, m_rvalid,
        input  s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
               s_araddr, s_arvalid, s_rready,
        output s_awready, s_wready, s_bvalid, s_bresp,
               s_arready, s_rdata, s_rresp, s_rvalid
    );
endinterface
`default_nettype wire

// File: rtl/axil_demux.sv
`default_nettype none
// ============================================================================
// Module      : axil_demux
// Description : Single-master, NUM_SLAVES-port AXI4-Lite address demux.
//               One outstanding write and one outstanding read, handled by
//               independent FSMs. Address/data/strobes are broadcast to all
//               slaves; only valid/ready are steered. Slaves that accept AW
//               and W in different cycles are absorbed so the upstream
//               bridge always sees awready and wready together. Unmapped
//               addresses get a DECERR response one cycle after acceptance.
// Ports       : clk    clock
//               rst_n  asynchronous active-low reset
//               bus    axil_demux_if.slave (upstream m_*, downstream s_*)
// Revision    : 1.0 - initial release
// ============================================================================
module axil_demux #(
    parameter int                       NUM_SLAVES = 4,
    parameter logic [NUM_SLAVES*32-1:0] SLV_BASE   = {32'h3000_0000, 32'h2000_0000,
                                                      32'h1000_0000, 32'h0000_0000},
    parameter logic [NUM_SLAVES*32-1:0] SLV_MASK   = {4{32'hF000_0000}}
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    axil_demux_if.slave      bus
);
    localparam int SEL_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

    typedef enum logic [1:0] {W_IDLE = 2'd0, W_PART = 2'd1, W_RESP = 2'd2, W_ERR = 2'd3} wstate_t;
    typedef enum logic [1:0] {R_IDLE = 2'd0, R_RESP = 2'd1, R_ERR = 2'd2} rstate_t;

    wstate_t             r_wstate, w_wstate_nxt;
    rstate_t             r_rstate, w_rstate_nxt;
    logic [SEL_W-1:0]    r_wsel, w_wsel_nxt, r_rsel, w_rsel_nxt;
    logic                r_aw_done, w_aw_done_nxt, r_w_done, w_w_done_nxt;

    logic                w_aw_hit, w_ar_hit;
    logic [SEL_W-1:0]    w_aw_sel, w_ar_sel;

    logic                w_m_awready, w_m_wready, w_m_bvalid, w_m_arready, w_m_rvalid;
    logic [1:0]          w_m_bresp, w_m_rresp;
    logic [31:0]         w_m_rdata;
    logic [NUM_SLAVES-1:0] w_s_awvalid, w_s_wvalid, w_s_bready, w_s_arvalid, w_s_rready;

    // Decode: scan from the top index down so the lowest match wins.
    always_comb begin
        w_aw_hit = 1'b0;
        w_aw_sel = '0;
        w_ar_hit = 1'b0;
        w_ar_sel = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if ((bus.m_awaddr & SLV_MASK[32*i +: 32]) == (SLV_BASE[32*i +: 32] & SLV_MASK[32*i +: 32])) begin
                w_aw_hit = 1'b1;
                w_aw_sel = SEL_W'(i);
            end
            if ((bus.m_araddr & SLV_MASK[32*i +: 32]) == (SLV_BASE[32*i +: 32] & SLV_MASK[32*i +: 32])) begin
                w_ar_hit = 1'b1;
                w_ar_sel = SEL_W'(i);
            end
        end
    end

    // ------------------------------------------------------------------ write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wstate  <= W_IDLE;
            r_wsel    <= '0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
        end else begin
            r_wstate  <= w_wstate_nxt;
            r_wsel    <= w_wsel_nxt;
            r_aw_done <= w_aw_done_nxt;
            r_w_done  <= w_w_done_nxt;
        end
    end

    always_comb begin
        w_wstate_nxt  = r_wstate;
        w_wsel_nxt    = r_wsel;
        w_aw_done_nxt = r_aw_done;
        w_w_done_nxt  = r_w_done;
        w_m_awready   = 1'b0;
        w_m_wready    = 1'b0;
        w_m_bvalid    = 1'b0;
        w_m_bresp     = 2'b00;
        w_s_awvalid   = '0;
        w_s_wvalid    = '0;
        w_s_bready    = '0;
        unique case (r_wstate)
            W_IDLE: begin
                // Only start once both AW and W are offered, so the pair can
                // be acknowledged upstream in a single cycle.
                if (bus.m_awvalid && bus.m_wvalid) begin
                    if (w_aw_hit) begin
                        w_s_awvalid[w_aw_sel] = 1'b1;
                        w_s_wvalid[w_aw_sel]  = 1'b1;
                        w_wsel_nxt            = w_aw_sel;
                        if (bus.s_awready[w_aw_sel] && bus.s_wready[w_aw_sel]) begin
                            w_m_awready  = 1'b1;
                            w_m_wready   = 1'b1;
                            w_wstate_nxt = W_RESP;
                        end else if (bus.s_awready[w_aw_sel]) begin
                            w_aw_done_nxt = 1'b1;
                            w_wstate_nxt  = W_PART;
                        end else if (bus.s_wready[w_aw_sel]) begin
                            w_w_done_nxt = 1'b1;
                            w_wstate_nxt = W_PART;
                        end
                    end else begin
                        w_m_awready  = 1'b1;
                        w_m_wready   = 1'b1;
                        w_wstate_nxt = W_ERR;
                    end
                end
            end
            W_PART: begin
                // Master holds AW/W valid (not yet acknowledged); keep
                // offering only the channel the slave has not taken.
                w_s_awvalid[r_wsel] = !r_aw_done;
                w_s_wvalid[r_wsel]  = !r_w_done;
                if ((r_aw_done || bus.s_awready[r_wsel]) && (r_w_done || bus.s_wready[r_wsel])) begin
                    w_m_awready   = 1'b1;
                    w_m_wready    = 1'b1;
                    w_aw_done_nxt = 1'b0;
                    w_w_done_nxt  = 1'b0;
                    w_wstate_nxt  = W_RESP;
                end
            end
            W_RESP: begin
                w_m_bvalid         = bus.s_bvalid[r_wsel];
                w_m_bresp          = bus.s_bresp[2*r_wsel +: 2];
                w_s_bready[r_wsel] = bus.m_bready;
                if (bus.s_bvalid[r_wsel] && bus.m_bready) begin
                    w_wstate_nxt = W_IDLE;
                end
            end
            W_ERR: begin
                w_m_bvalid = 1'b1;
                w_m_bresp  = 2'b11;
                if (bus.m_bready) begin
                    w_wstate_nxt = W_IDLE;
                end
            end
            default: w_wstate_nxt = W_IDLE;
        endcase
        // Idle-state outputs follow master valids combinationally; silence
        // them while reset is held.
        if (!rst_n) begin
            w_m_awready = 1'b0;
            w_m_wready  = 1'b0;
            w_m_bvalid  = 1'b0;
            w_m_bresp   = 2'b00;
            w_s_awvalid = '0;
            w_s_wvalid  = '0;
            w_s_bready  = '0;
        end
    end

    // ------------------------------------------------------------------- read
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rstate <= R_IDLE;
            r_rsel   <= '0;
        end else begin
            r_rstate <= w_rstate_nxt;
            r_rsel   <= w_rsel_nxt;
        end
    end

    always_comb begin
        w_rstate_nxt = r_rstate;
        w_rsel_nxt   = r_rsel;
        w_m_arready  = 1'b0;
        w_m_rvalid   = 1'b0;
        w_m_rdata    = 32'h0;
        w_m_rresp    = 2'b00;
        w_s_arvalid  = '0;
        w_s_rready   = '0;
        unique case (r_rstate)
            R_IDLE: begin
                if (w_ar_hit) begin
                    w_s_arvalid[w_ar_sel] = bus.m_arvalid;
                    w_m_arready           = bus.s_arready[w_ar_sel];
                    if (bus.m_arvalid && bus.s_arready[w_ar_sel]) begin
                        w_rsel_nxt   = w_ar_sel;
                        w_rstate_nxt = R_RESP;
                    end
                end else if (bus.m_arvalid) begin
                    w_m_arready  = 1'b1;
                    w_rstate_nxt = R_ERR;
                end
            end
            R_RESP: begin
                w_m_rvalid         = bus.s_rvalid[r_rsel];
                w_m_rdata          = bus.s_rdata[32*r_rsel +: 32];
                w_m_rresp          = bus.s_rresp[2*r_rsel +: 2];
                w_s_rready[r_rsel] = bus.m_rready;
                if (bus.s_rvalid[r_rsel] && bus.m_rready) begin
                    w_rstate_nxt = R_IDLE;
                end
            end
            R_ERR: begin
                w_m_rvalid = 1'b1;
                w_m_rresp  = 2'b11;
                if (bus.m_rready) begin
                    w_rstate_nxt = R_IDLE;
                end
            end
            default: w_rstate_nxt = R_IDLE;
        endcase
        if (!rst_n) begin
            w_m_arready = 1'b0;
            w_m_rvalid  = 1'b0;
            w_m_rdata   = 32'h0;
            w_m_rresp   = 2'b00;
            w_s_arvalid = '0;
            w_s_rready  = '0;
        end
    end

    // ---------------------------------------------------------------- outputs
    assign bus.m_awready = w_m_awready;
    assign bus.m_wready  = w_m_wready;
    assign bus.m_bvalid  = w_m_bvalid;
    assign bus.m_bresp   = w_m_bresp;
    assign bus.m_arready = w_m_arready;
    assign bus.m_rvalid  = w_m_rvalid;
    assign bus.m_rdata   = w_m_rdata;
    assign bus.m_rresp   = w_m_rresp;

    assign bus.s_awaddr  = {NUM_SLAVES{bus.m_awaddr}};
    assign bus.s_wdata   = {NUM_SLAVES{bus.m_wdata}};
    assign bus.s_wstrb   = {NUM_SLAVES{bus.m_wstrb}};
    assign bus.s_araddr  = {NUM_SLAVES{bus.m_araddr}};
    assign bus.s_awvalid = w_s_awvalid;
    assign bus.s_wvalid  = w_s_wvalid;
    assign bus.s_bready  = w_s_bready;
    assign bus.s_arvalid = w_s_arvalid;
    assign bus.s_rready  = w_s_rready;
endmodule
`default_nettype wire

// File: tb/tb_axil_demux.sv
`default_nettype none
// ============================================================================
// Module      : tb_axil_demux
// Description : Self-checking bench for axil_demux. Inputs change on the
//               falling edge, outputs are sampled 1 ns later. Expected B/R
//               responses are queued when a transaction is accepted and
//               popped when the master-side handshake happens.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axil_demux;
    localparam int NS = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    axil_demux_if #(.NUM_SLAVES(NS)) bus ();
    axil_demux #(.NUM_SLAVES(NS)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int n_checks = 0;
    int n_fail   = 0;
    logic [1:0]  exp_b[$];
    logic [33:0] exp_r[$];
    logic [1:0]  e_b;
    logic [33:0] e_r;

    int aw_beats[NS];
    int w_beats[NS];
    always @(posedge clk) begin
        for (int i = 0; i < NS; i++) begin
            if (bus.s_awvalid[i] && bus.s_awready[i]) aw_beats[i] <= aw_beats[i] + 1;
            if (bus.s_wvalid[i] && bus.s_wready[i])   w_beats[i]  <= w_beats[i] + 1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.m_awaddr = '0; bus.m_awvalid = 1'b0; bus.m_wdata = '0; bus.m_wstrb = '0;
        bus.m_wvalid = 1'b0; bus.m_bready = 1'b0; bus.m_araddr = '0; bus.m_arvalid = 1'b0;
        bus.m_rready = 1'b0;
        bus.s_awready = '0; bus.s_wready = '0; bus.s_bvalid = '0; bus.s_bresp = '0;
        bus.s_arready = '0; bus.s_rdata = '0; bus.s_rresp = '0; bus.s_rvalid = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        bus.m_awvalid = 1'b1; bus.m_wvalid = 1'b1; bus.m_arvalid = 1'b1;
        bus.s_awready = '1; bus.s_wready = '1; bus.s_arready = '1;
        cyc(); cyc(); #1;
        n_checks++; if (bus.s_awvalid !== 4'b0 || bus.s_wvalid !== 4'b0 || bus.s_arvalid !== 4'b0) begin
            n_fail++; $display("FAIL rst_s_valid: got aw=%b w=%b ar=%b required 0", bus.s_awvalid, bus.s_wvalid, bus.s_arvalid); end
        n_checks++; if (bus.m_awready !== 1'b0 || bus.m_wready !== 1'b0 || bus.m_arready !== 1'b0) begin
            n_fail++; $display("FAIL rst_m_ready: got aw=%b w=%b ar=%b required 0", bus.m_awready, bus.m_wready, bus.m_arready); end
        n_checks++; if (bus.m_bvalid !== 1'b0 || bus.m_rvalid !== 1'b0 || bus.m_rdata !== 32'h0 || bus.m_rresp !== 2'b0 || bus.m_bresp !== 2'b0) begin
            n_fail++; $display("FAIL rst_resp: got bv=%b rv=%b rdata=%h rresp=%b bresp=%b required 0", bus.m_bvalid, bus.m_rvalid, bus.m_rdata, bus.m_rresp, bus.m_bresp); end
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        cyc(); #1;
        n_checks++; if (bus.m_bvalid !== 1'b0 || bus.m_rvalid !== 1'b0) begin
            n_fail++; $display("FAIL post_rst_valid: got bv=%b rv=%b required 0", bus.m_bvalid, bus.m_rvalid); end
    endtask

    task automatic test_write_same_cycle();
        @(negedge clk);
        bus.m_awaddr = 32'h2000_0004; bus.m_wdata = 32'hA5A5_0001; bus.m_wstrb = 4'hF;
        bus.m_awvalid = 1'b1; bus.m_wvalid = 1'b1;
        bus.s_awready = 4'b0100; bus.s_wready = 4'b0100;
        #1;
        n_checks++; if (bus.m_awready !== 1'b1 || bus.m_wready !== 1'b1) begin
            n_fail++; $display("FAIL wr2_ready: got aw=%b w=%b required 1 1", bus.m_awready, bus.m_wready); end
        n_checks++; if (bus.s_awvalid !== 4'b0100 || bus.s_wvalid !== 4'b0100) begin
            n_fail++; $display("FAIL wr2_route: got aw=%b w=%b required 0100", bus.s_awvalid, bus.s_wvalid); end
        n_checks++; if (bus.s_wdata[64 +: 32] !== 32'hA5A5_0001 || bus.s_awaddr[64 +: 32] !== 32'h2000_0004 || bus.s_wstrb[8 +: 4] !== 4'hF) begin
            n_fail++; $display("FAIL wr2_bcast: got addr=%h data=%h strb=%h", bus.s_awaddr[64 +: 32], bus.s_wdata[64 +: 32], bus.s_wstrb[8 +: 4]); end
        exp_b.push_back(2'b00);
        cyc();
        bus.m_awvalid = 1'b0; bus.m_wvalid = 1'b0; bus.s_awready = '0; bus.s_wready = '0;
        bus.s_bvalid = 4'b0100; bus.s_bresp = 8'b00_00_00_00; bus.m_bready = 1'b1;
        #1;
        n_checks++; if (bus.m_bvalid !== 1'b1 || bus.s_bready !== 4'b0100) begin
            n_fail++; $display("FAIL wr2_b: got bvalid=%b s_bready=%b required 1 0100", bus.m_bvalid, bus.s_bready); end
        e_b = (exp_b.size() > 0) ? exp_b.pop_front() : 2'bxx;
        n_checks++; if (bus.m_bresp !== e_b) begin
            n_fail++; $display("FAIL wr2_bresp: got %b required %b", bus.m_bresp, e_b); end
        n_checks++; if (bus.s_awvalid !== 4'b0 || bus.s_wvalid !== 4'b0 || bus.s_arvalid !== 4'b0) begin
            n_fail++; $display("FAIL wr2_quiet: got aw=%b w=%b ar=%b required 0", bus.s_awvalid, bus.s_wvalid, bus.s_arvalid); end
        cyc();
        idle_inputs(); #1;
        n_checks++; if (bus.m_bvalid !== 1'b0) begin
            n_fail++; $display("FAIL wr2_bdone: got bvalid=%b required 0", bus.m_bvalid); end
    endtask

    task automatic test_write_split();
        int aw0, w0;
        @(negedge clk);
        aw0 = aw_beats[1]; w0 = w_beats[1];
        bus.m_awaddr = 32'h1000_0000; bus.m_wdata = 32'h0000_BEEF; bus.m_wstrb = 4'h3;
        bus.m_awvalid = 1'b1; bus.m_wvalid = 1'b1;
        bus.s_awready = 4'b0010; bus.s_wready = 4'b0000;
        #1;
        n_checks++; if (bus.m_awready !== 1'b0 || bus.m_wready !== 1'b0 || bus.s_awvalid !== 4'b0010) begin
            n_fail++; $display("FAIL split_n: got awr=%b wr=%b s_awvalid=%b required 0 0 0010", bus.m_awready, bus.m_wready, bus.s_awvalid); end
        cyc();
        bus.s_awready = 4'b0000; #1;
        n_checks++; if (bus.s_awvalid !== 4'b0000 || bus.s_wvalid !== 4'b0010 || bus.m_awready !== 1'b0 || bus.m_wready !== 1'b0) begin
            n_fail++; $display("FAIL split_n1: got s_aw=%b s_w=%b awr=%b wr=%b required 0000 0010 0 0", bus.s_awvalid, bus.s_wvalid, bus.m_awready, bus.m_wready); end
        cyc();
        bus.s_wready = 4'b0010; #1;
        n_checks++; if (bus.m_awready !== 1'b1 || bus.m_wready !== 1'b1 || bus.s_awvalid !== 4'b0000) begin
            n_fail++; $display("FAIL split_n2: got awr=%b wr=%b s_aw=%b required 1 1 0000", bus.m_awready, bus.m_wready, bus.s_awvalid); end
        exp_b.push_back(2'b01);
        cyc();
        bus.m_awvalid = 1'b0; bus.m_wvalid = 1'b0; bus.s_wready = '0;
        bus.s_bvalid = 4'b0010; bus.s_bresp = 8'b00_00_01_00; bus.m_bready = 1'b1;
        #1;
        n_checks++; if (aw_beats[1] - aw0 !== 1 || w_beats[1] - w0 !== 1) begin
            n_fail++; $display("FAIL split_beats: got aw=%0d w=%0d required 1 1", aw_beats[1] - aw0, w_beats[1] - w0); end
        e_b = (exp_b.size() > 0) ? exp_b.pop_front() : 2'bxx;
        n_checks++; if (bus.m_bvalid !== 1'b1 || bus.m_bresp !== e_b) begin
            n_fail++; $display("FAIL split_b: got bvalid=%b bresp=%b required 1 %b", bus.m_bvalid, bus.m_bresp, e_b); end
        cyc();
        idle_inputs();
    endtask

    task automatic test_read();
        @(negedge clk);
        bus.m_araddr = 32'h3000_0010; bus.m_arvalid = 1'b1; bus.s_arready = 4'b1000;
        #1;
        n_checks++; if (bus.m_arready !== 1'b1 || bus.s_arvalid !== 4'b1000 || bus.s_araddr[96 +: 32] !== 32'h3000_0010) begin
            n_fail++; $display("FAIL rd3_ar: got arready=%b s_arvalid=%b addr=%h", bus.m_arready, bus.s_arvalid, bus.s_araddr[96 +: 32]); end
        exp_r.push_back({32'h1234_5678, 2'b00});
        cyc();
        bus.m_arvalid = 1'b0; bus.s_arready = '0; bus.m_rready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            #1;
            n_checks++; if (bus.m_rvalid !== 1'b0 || bus.s_arvalid !== 4'b0) begin
                n_fail++; $display("FAIL rd3_wait%0d: got rvalid=%b s_arvalid=%b required 0", k, bus.m_rvalid, bus.s_arvalid); end
            cyc();
        end
        bus.s_rvalid = 4'b1000; bus.s_rdata[96 +: 32] = 32'h1234_5678; bus.s_rresp = '0;
        #1;
        e_r = (exp_r.size() > 0) ? exp_r.pop_front() : 'x;
        n_checks++; if (bus.m_rvalid !== 1'b1 || {bus.m_rdata, bus.m_rresp} !== e_r || bus.s_rready !== 4'b1000) begin
            n_fail++; $display("FAIL rd3_r: got rvalid=%b data/resp=%h s_rready=%b required 1 %h 1000", bus.m_rvalid, {bus.m_rdata, bus.m_rresp}, bus.s_rready, e_r); end
        cyc();
        idle_inputs(); #1;
        n_checks++; if (bus.m_rvalid !== 1'b0 || bus.m_rdata !== 32'h0) begin
            n_fail++; $display("FAIL rd3_done: got rvalid=%b rdata=%h required 0", bus.m_rvalid, bus.m_rdata); end
    endtask

    task automatic test_decerr();
        @(negedge clk);
        bus.m_araddr = 32'h5000_0000; bus.m_arvalid = 1'b1;
        bus.m_awaddr = 32'h7000_0000; bus.m_awvalid = 1'b1; bus.m_wvalid = 1'b1;
        #1;
        n_checks++; if (bus.m_arready !== 1'b1 || bus.m_awready !== 1'b1 || bus.m_wready !== 1'b1) begin
            n_fail++; $display("FAIL err_accept: got ar=%b aw=%b w=%b required 1 1 1", bus.m_arready, bus.m_awready, bus.m_wready); end
        n_checks++; if (bus.s_arvalid !== 4'b0 || bus.s_awvalid !== 4'b0 || bus.s_wvalid !== 4'b0) begin
            n_fail++; $display("FAIL err_noroute: got ar=%b aw=%b w=%b required 0", bus.s_arvalid, bus.s_awvalid, bus.s_wvalid); end
        exp_r.push_back({32'h0, 2'b11});
        exp_b.push_back(2'b11);
        cyc();
        idle_inputs();
        for (int k = 0; k < 3; k++) begin
            #1;
            n_checks++; if (bus.m_rvalid !== 1'b1 || {bus.m_rdata, bus.m_rresp} !== {32'h0, 2'b11} || bus.m_bvalid !== 1'b1 || bus.m_bresp !== 2'b11) begin
                n_fail++; $display("FAIL err_hold%0d: got rv=%b rdata=%h rresp=%b bv=%b bresp=%b", k, bus.m_rvalid, bus.m_rdata, bus.m_rresp, bus.m_bvalid, bus.m_bresp); end
            cyc();
        end
        bus.m_rready = 1'b1; bus.m_bready = 1'b1; #1;
        e_r = (exp_r.size() > 0) ? exp_r.pop_front() : 'x;
        e_b = (exp_b.size() > 0) ? exp_b.pop_front() : 2'bxx;
        n_checks++; if (bus.m_rvalid !== 1'b1 || {bus.m_rdata, bus.m_rresp} !== e_r || bus.m_bvalid !== 1'b1 || bus.m_bresp !== e_b) begin
            n_fail++; $display("FAIL err_resp: got r=%h b=%b required %h %b", {bus.m_rdata, bus.m_rresp}, bus.m_bresp, e_r, e_b); end
        cyc();
        idle_inputs(); #1;
        n_checks++; if (bus.m_rvalid !== 1'b0 || bus.m_bvalid !== 1'b0) begin
            n_fail++; $display("FAIL err_done: got rv=%b bv=%b required 0 0", bus.m_rvalid, bus.m_bvalid); end
    endtask

    task automatic test_concurrent();
        @(negedge clk);
        bus.m_araddr = 32'h0000_0100; bus.m_arvalid = 1'b1; bus.s_arready = 4'b0001;
        bus.m_awaddr = 32'h2000_0008; bus.m_wdata = 32'h5555_AAAA; bus.m_wstrb = 4'hC;
        bus.m_awvalid = 1'b1; bus.m_wvalid = 1'b1; bus.s_awready = 4'b0100; bus.s_wready = 4'b0100;
        #1;
        n_checks++; if (bus.s_arvalid !== 4'b0001 || bus.s_awvalid !== 4'b0100 || bus.m_arready !== 1'b1 || bus.m_awready !== 1'b1) begin
            n_fail++; $display("FAIL cc_accept: got s_ar=%b s_aw=%b arr=%b awr=%b", bus.s_arvalid, bus.s_awvalid, bus.m_arready, bus.m_awready); end
        exp_r.push_back({32'hCAFE_0000, 2'b00});
        exp_b.push_back(2'b00);
        cyc();
        idle_inputs();
        bus.s_rvalid = 4'b0101; bus.s_rdata[0 +: 32] = 32'hCAFE_0000; bus.s_rdata[64 +: 32] = 32'hBAD0_BAD0;
        bus.s_rresp = 8'b00_10_00_00;
        bus.s_bvalid = 4'b0101; bus.s_bresp = 8'b00_00_00_10;
        bus.m_rready = 1'b1; bus.m_bready = 1'b1;
        #1;
        e_r = (exp_r.size() > 0) ? exp_r.pop_front() : 'x;
        e_b = (exp_b.size() > 0) ? exp_b.pop_front() : 2'bxx;
        n_checks++; if (bus.m_rvalid !== 1'b1 || {bus.m_rdata, bus.m_rresp} !== e_r || bus.s_rready !== 4'b0001) begin
            n_fail++; $display("FAIL cc_r: got rv=%b r=%h s_rready=%b required 1 %h 0001", bus.m_rvalid, {bus.m_rdata, bus.m_rresp}, bus.s_rready, e_r); end
        n_checks++; if (bus.m_bvalid !== 1'b1 || bus.m_bresp !== e_b || bus.s_bready !== 4'b0100) begin
            n_fail++; $display("FAIL cc_b: got bv=%b bresp=%b s_bready=%b required 1 %b 0100", bus.m_bvalid, bus.m_bresp, bus.s_bready, e_b); end
        cyc();
        idle_inputs(); #1;
        n_checks++; if (bus.m_rvalid !== 1'b0 || bus.m_bvalid !== 1'b0) begin
            n_fail++; $display("FAIL cc_done: got rv=%b bv=%b required 0 0", bus.m_rvalid, bus.m_bvalid); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        bus.m_awaddr = 32'h1000_0020; bus.m_awvalid = 1'b1; bus.m_wvalid = 1'b1;
        bus.s_awready = 4'b0010; bus.s_wready = 4'b0010;
        cyc();
        // Now in the response phase with bvalid low; master offers the next write.
        bus.s_awready = 4'b0001; bus.s_wready = 4'b0001; bus.m_awaddr = 32'h0000_0040;
        bus.m_bready = 1'b1; #1;
        n_checks++; if (bus.s_awvalid !== 4'b0 || bus.m_awready !== 1'b0 || bus.m_bvalid !== 1'b0) begin
            n_fail++; $display("FAIL mid_resp: got s_aw=%b awr=%b bv=%b required 0 0 0", bus.s_awvalid, bus.m_awready, bus.m_bvalid); end
        rst_n = 1'b0; #1;
        n_checks++; if (bus.m_bvalid !== 1'b0 || bus.s_awvalid !== 4'b0 || bus.s_wvalid !== 4'b0 || bus.s_arvalid !== 4'b0 || bus.m_awready !== 1'b0) begin
            n_fail++; $display("FAIL mid_rst: got bv=%b s_aw=%b s_w=%b s_ar=%b awr=%b required all 0", bus.m_bvalid, bus.s_awvalid, bus.s_wvalid, bus.s_arvalid, bus.m_awready); end
        cyc();
        rst_n = 1'b1; #1;
        n_checks++; if (bus.m_awready !== 1'b1 || bus.m_wready !== 1'b1 || bus.s_awvalid !== 4'b0001) begin
            n_fail++; $display("FAIL mid_new: got awr=%b wr=%b s_aw=%b required 1 1 0001", bus.m_awready, bus.m_wready, bus.s_awvalid); end
        exp_b.push_back(2'b00);
        cyc();
        bus.m_awvalid = 1'b0; bus.m_wvalid = 1'b0; bus.s_awready = '0; bus.s_wready = '0;
        bus.s_bvalid = 4'b0011; bus.s_bresp = 8'b00_00_10_00; #1;
        e_b = (exp_b.size() > 0) ? exp_b.pop_front() : 2'bxx;
        n_checks++; if (bus.m_bvalid !== 1'b1 || bus.m_bresp !== e_b || bus.s_bready !== 4'b0001) begin
            n_fail++; $display("FAIL mid_b: got bv=%b bresp=%b s_bready=%b required 1 %b 0001", bus.m_bvalid, bus.m_bresp, bus.s_bready, e_b); end
        cyc();
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_write_same_cycle();
        test_write_split();
        test_read();
        test_decerr();
        test_concurrent();
        test_reset_mid();
        n_checks++; if (exp_b.size() != 0 || exp_r.size() != 0) begin
            n_fail++; $display("FAIL scoreboard_drain: got b=%0d r=%0d pending required 0", exp_b.size(), exp_r.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/axil_demux.md
Name: axil_demux

Overview:
- Single-master, NUM_SLAVES-port AXI4-Lite address demultiplexer.
- Sits directly downstream of the core's OBI-to-AXI4-Lite bridge and routes each read/write to one peripheral slave (memory, UART, timer, GPIO) by address decode.
- Allows one outstanding write and one outstanding read, independently.
- Absorbs slaves that accept AW and W in different cycles; the upstream bridge needs awready and wready in the same cycle.
- Returns DECERR for unmapped addresses.

Parameters:
- NUM_SLAVES, 4, number of slave ports (1..8).
- SLV_BASE, {32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000}, packed NUM_SLAVES*32 base addresses; slave i uses bits [32*i+:32].
- SLV_MASK, {4{32'hF000_0000}}, packed NUM_SLAVES*32 decode masks; slave i hits when (addr & mask_i) == (base_i & mask_i).

Ports:
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- m_awaddr  in  32  master write address
- m_awvalid  in  1  master write address valid
- m_awready  out  1  write address accepted
- m_wdata  in  32  master write data
- m_wstrb  in  4  master write byte strobes
- m_wvalid  in  1  master write data valid
- m_wready  out  1  write data accepted
- m_bvalid  out  1  write response valid
- m_bready  in  1  master ready for write response
- m_bresp  out  2  write response code
- m_araddr  in  32  master read address
- m_arvalid  in  1  master read address valid
- m_arready  out  1  read address accepted
- m_rdata  out  32  read data
- m_rresp  out  2  read response code
- m_rvalid  out  1  read data valid
- m_rready  in  1  master ready for read data
- s_awaddr  out  NUM_SLAVES*32  per-slave write address
- s_awvalid  out  NUM_SLAVES  per-slave write address valid
- s_awready  in  NUM_SLAVES  per-slave write address ready
- s_wdata  out  NUM_SLAVES*32  per-slave write data
- s_wstrb  out  NUM_SLAVES*4  per-slave write strobes
- s_wvalid  out  NUM_SLAVES  per-slave write data valid
- s_wready  in  NUM_SLAVES  per-slave write data ready
- s_bvalid  in  NUM_SLAVES  per-slave write response valid
- s_bready  out  NUM_SLAVES  per-slave write response ready
- s_bresp  in  NUM_SLAVES*2  per-slave write response code
- s_araddr  out  NUM_SLAVES*32  per-slave read address
- s_arvalid  out  NUM_SLAVES  per-slave read address valid
- s_arready  in  NUM_SLAVES  per-slave read address ready
- s_rdata  in  NUM_SLAVES*32  per-slave read data
- s_rresp  in  NUM_SLAVES*2  per-slave read response code
- s_rvalid  in  NUM_SLAVES  per-slave read data valid
- s_rready  out  NUM_SLAVES  per-slave read data ready

Behaviour:
- **Reset:** clk rising edge; rst_n async, active-low. Reset forces both FSMs to IDLE and clears aw_done, w_done, wsel and rsel. All valid/ready outputs are 0; m_bresp, m_rresp and m_rdata are 0.
- **Address, data and strobes:** broadcast to all slaves combinationally; only valid/ready are steered. Unselected slaves always see valid=0 and bready=rready=0.
- **Decode:** combinational; lowest matching index wins on overlap; no match = miss.
- **Write FSM: W_IDLE, W_PART, W_RESP, W_ERR.**
  - W_IDLE, hit: when m_awvalid and m_wvalid are both 1, drive s_awvalid[sel] = s_wvalid[sel] = 1 and latch sel into wsel.
    - Both slave readies high: m_awready = m_wready = 1 the same cycle, then go to W_RESP.
    - Only one ready high: set the matching done flag, give no master ready, go to W_PART.
    - AW alone or W alone from the master is ignored until both are valid.
  - W_IDLE, miss: m_awready = m_wready = 1 the same cycle, then go to W_ERR.
  - W_PART: drive valid only on the not-yet-accepted channel of slave wsel. When it is accepted, m_awready = m_wready = 1 that cycle, clear the done flags, go to W_RESP.
  - W_RESP: m_bvalid = s_bvalid[wsel]; m_bresp = s_bresp[wsel]; s_bready[wsel] = m_bready. On the bvalid && bready handshake, go to W_IDLE; a new AW/W is accepted no earlier than the next cycle.
  - W_ERR: m_bvalid = 1 and m_bresp = 2'b11 (DECERR) starting the cycle after acceptance; held until m_bready, then go to W_IDLE.
- **Read FSM: R_IDLE, R_RESP, R_ERR.**
  - R_IDLE, hit: s_arvalid[sel] = m_arvalid; m_arready = s_arready[sel]. On the handshake, latch rsel and go to R_RESP.
  - R_IDLE, miss: m_arready = 1, then go to R_ERR.
  - R_RESP: m_rvalid, m_rdata and m_rresp pass through from slave rsel; s_rready[rsel] = m_rready. On the handshake, go to R_IDLE.
  - R_ERR: m_rvalid = 1, m_rdata = 32'h0, m_rresp = 2'b11, held until m_rready.
- **Idle response outputs:** outside W_RESP/W_ERR and R_RESP/R_ERR, m_bvalid = m_rvalid = 0; m_bresp, m_rresp and m_rdata are 0.
- **Read/write independence:** both FSMs run independently; a simultaneous read and write to the same or different slaves proceed concurrently.
- **Latency:** zero added cycles on the handshake paths (combinational pass-through). The error response arrives 1 cycle after acceptance.
- **Reset mid-transaction:** the FSMs abort to IDLE with no further valids; slave-side state is the slaves' concern.

Test Plan:
- Write 0x2000_0004 (data 0xA5A5_0001, strb 4'hF); slave 2 raises awready and wready in the same cycle -> m_awready = m_wready = 1 that cycle; s_bvalid[2] with bresp=0 -> m_bvalid=1, m_bresp=0 in the same cycle; other slaves' valids stay 0 throughout.
- Write 0x1000_0000; slave 1 gives awready in cycle N and wready in cycle N+2 -> s_awvalid[1] drops after N; m_awready = m_wready = 1 only in N+2; exactly one AW and one W beat seen at slave 1.
- Read 0x3000_0010; slave 3 holds arready=1 and returns rdata 0x1234_5678 three cycles later -> m_rdata = 0x1234_5678, m_rresp = 0, m_rvalid for one cycle with m_rready=1.
- Read 0x5000_0000 and write 0x7000_0000 (unmapped) -> m_arready=1 and m_awready = m_wready = 1 immediately; next cycle m_rvalid=1, m_rdata=0, m_rresp=2'b11 and m_bvalid=1, m_bresp=2'b11; both held while ready is low for 3 cycles.
- Concurrent read of slave 0 and write to slave 2 in the same cycle -> both complete independently with correct routing; no cross-talk between rsel and wsel.
- Assert rst_n=0 while in W_RESP with s_bvalid low -> m_bvalid=0 and all s_*valid=0 immediately; after release, a new write to slave 0 completes normally.
